// File: rtl/pwm_dead_time_stage.sv
// pwm_dead_time_stage: complementary high/low pad drive with programmable dead time
// and a latched fault that forces every channel to the both-off safe state.
module pwm_dead_time_stage #(
  parameter int OUTPUTS    = 4,
  parameter int DEAD_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [OUTPUTS-1:0]    pwm_in,
  input  logic [OUTPUTS-1:0]    pwm_en,
  input  logic [OUTPUTS-1:0]    complementaryEnable,
  input  logic [DEAD_WIDTH-1:0] deadTime,
  input  logic                  fault,
  input  logic                  faultClear,
  output logic [OUTPUTS-1:0]    pwm_high,
  output logic [OUTPUTS-1:0]    pwm_low,
  output logic [OUTPUTS-1:0]    pwm_high_en,
  output logic [OUTPUTS-1:0]    pwm_low_en,
  output logic                  fault_irq
);
  typedef enum logic [2:0] {OFF, LOW, DEAD_H, HIGH, DEAD_L} state_t;
  logic [OUTPUTS-1:0] pwm_q, en_q;
  logic               fault_latched;
  logic               dead_zero;
  assign dead_zero = deadTime == '0;
  assign fault_irq = fault_latched;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pwm_q         <= '0;
      en_q          <= '0;
      pwm_high_en   <= '0;
      pwm_low_en    <= '0;
      fault_latched <= 1'b0;
    end else begin
      pwm_q         <= pwm_in;
      en_q          <= pwm_en;
      pwm_high_en   <= en_q;
      pwm_low_en    <= en_q & complementaryEnable;
      fault_latched <= fault | (fault_latched & ~faultClear);
    end
  for (genvar i = 0; i < OUTPUTS; i++) begin : g_ch
    state_t                state, nxt;
    logic [DEAD_WIDTH-1:0] cnt, nxt_cnt;
    logic                  hi, lo;
    always_comb begin
      nxt     = state;
      nxt_cnt = cnt;
      if (fault_latched || !en_q[i]) nxt = OFF;
      else if (!complementaryEnable[i]) nxt = pwm_q[i] ? HIGH : OFF;
      else
        case (state)
          OFF, LOW:
            if (!pwm_q[i]) nxt = LOW;
            else begin
              nxt     = dead_zero ? HIGH : DEAD_H;
              nxt_cnt = deadTime;
            end
          DEAD_H:
            if (!pwm_q[i]) nxt = LOW;
            else if (cnt == DEAD_WIDTH'(1)) nxt = HIGH;
            else nxt_cnt = cnt - 1'b1;
          HIGH:
            if (!pwm_q[i]) begin
              nxt     = dead_zero ? LOW : DEAD_L;
              nxt_cnt = deadTime;
            end
          DEAD_L:
            if (pwm_q[i]) nxt = HIGH;
            else if (cnt == DEAD_WIDTH'(1)) nxt = LOW;
            else nxt_cnt = cnt - 1'b1;
          default: nxt = OFF;
        endcase
    end
    // drives decode the next state so they change on the same edge as the state
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        state <= OFF;
        cnt   <= '0;
        hi    <= 1'b0;
        lo    <= 1'b0;
      end else begin
        state <= nxt;
        cnt   <= nxt_cnt;
        hi    <= nxt == HIGH;
        lo    <= nxt == LOW;
      end
    assign pwm_high[i] = hi;
    assign pwm_low[i]  = lo;
  end
endmodule

// File: tb/tb_pwm_dead_time_stage.sv
// tb_pwm_dead_time_stage: directed and random stimulus checked against a run-length
// model of the dead-time rules.
module tb_pwm_dead_time_stage;
  localparam int N = 4;
  localparam int DW = 8;
  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  pwm_in, pwm_en, comp;
  logic [DW-1:0] dead;
  logic          fault, fault_clear;
  logic [N-1:0]  pwm_high, pwm_low, pwm_high_en, pwm_low_en;
  logic          fault_irq;
  int vectors = 0;
  int miscompares = 0;
  pwm_dead_time_stage #(.OUTPUTS(N), .DEAD_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in), .pwm_en(pwm_en),
    .complementaryEnable(comp), .deadTime(dead), .fault(fault), .faultClear(fault_clear),
    .pwm_high(pwm_high), .pwm_low(pwm_low), .pwm_high_en(pwm_high_en),
    .pwm_low_en(pwm_low_en), .fault_irq(fault_irq)
  );
  always #5 clk = ~clk;
  // committed side per channel (-1 none, 0 low, 1 high), run length of the current
  // captured level and the dead time captured when that run began
  int           side [N];
  int           prev [N];
  int           run  [N];
  int           dl   [N];
  logic [N-1:0] q_pwm, q_en, eh, el, ehe, ele;
  logic         flt;
  function automatic void reset_model();
    for (int c = 0; c < N; c++) begin
      side[c] = -1;
      prev[c] = -1;
      run[c]  = 0;
      dl[c]   = 0;
    end
    q_pwm = '0; q_en = '0; eh = '0; el = '0; ehe = '0; ele = '0; flt = 1'b0;
  endfunction
  function automatic void model_edge();
    int v;
    for (int c = 0; c < N; c++) begin
      v = int'(q_pwm[c]);
      if (flt || !q_en[c]) begin
        side[c] = -1; prev[c] = -1; eh[c] = 1'b0; el[c] = 1'b0;
      end else if (!comp[c]) begin
        side[c] = v == 1 ? 1 : -1; prev[c] = -1; eh[c] = q_pwm[c]; el[c] = 1'b0;
      end else begin
        if (v != prev[c]) begin
          run[c] = 1;
          dl[c]  = int'(dead);
        end else run[c]++;
        prev[c] = v;
        if (v != side[c] && ((side[c] == -1 && v == 0) || run[c] > dl[c])) side[c] = v;
        eh[c] = side[c] == 1 && v == 1;
        el[c] = side[c] == 0 && v == 0;
      end
    end
    ehe   = q_en;
    ele   = q_en & comp;
    q_pwm = pwm_in;
    q_en  = pwm_en;
    flt   = fault | (flt & ~fault_clear);
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_all();
    chk("high", 32'(pwm_high), 32'(eh));
    chk("low", 32'(pwm_low), 32'(el));
    chk("high_en", 32'(pwm_high_en), 32'(ehe));
    chk("low_en", 32'(pwm_low_en), 32'(ele));
    chk("irq", 32'(fault_irq), 32'(flt));
    chk("exclusive", 32'(pwm_high & pwm_low), 32'd0);
  endtask
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask
  initial begin
    rst = 1'b0; pwm_in = '0; pwm_en = '0; comp = '0; dead = '0; fault = 1'b0; fault_clear = 1'b0;
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b1;
    pwm_en = '1; comp = '1; dead = 8'd3; pwm_in = 4'b1010;
    for (int t = 0; t < 80; t++) begin
      pwm_in[0] = (t % 20) >= 10;
      tick();
    end
    dead = 8'd0;
    for (int t = 0; t < 16; t++) begin
      pwm_in = ((t / 4) % 2) != 0 ? '1 : '0;
      tick();
    end
    dead = 8'd5; pwm_in = '0;
    repeat (8) tick();
    pwm_in = '1;
    repeat (2) tick();
    pwm_in = '0;
    repeat (10) tick();
    chk("short_pulse_low", 32'(pwm_low), 32'hf);
    dead = 8'd2; pwm_in = '1;
    repeat (8) tick();
    fault = 1'b1;
    repeat (3) tick();
    chk("fault_drives_off", 32'(pwm_high | pwm_low), 32'd0);
    fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0;
    tick();
    fault = 1'b0;
    repeat (2) tick();
    chk("fault_held", 32'(fault_irq), 32'd1);
    fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0; pwm_in = 4'b0011;
    repeat (8) tick();
    pwm_en = '0;
    repeat (2) tick();
    comp = '0; dead = 8'd10; pwm_en = '1;
    for (int t = 0; t < 30; t++) begin
      pwm_in = N'($urandom);
      tick();
    end
    chk("noncomp_low_en", 32'(pwm_low_en), 32'd0);
    for (int t = 0; t < 500; t++) begin
      if ($urandom_range(3) == 0) pwm_in = pwm_in ^ N'($urandom);
      if ($urandom_range(39) == 0) pwm_en = pwm_en ^ N'($urandom);
      if ($urandom_range(49) == 0) comp = N'($urandom);
      if ($urandom_range(9) == 0) dead = DW'($urandom_range(6));
      fault = $urandom_range(79) == 0;
      fault_clear = $urandom_range(9) == 0;
      tick();
    end
    fault = 1'b0; fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0; comp = '1; pwm_en = '1; dead = 8'd255; pwm_in = '0;
    repeat (5) tick();
    pwm_in = '1;
    repeat (262) tick();
    chk("max_dead_high", 32'(pwm_high), 32'hf);
    dead = 8'd8; pwm_in = '0;
    repeat (4) tick();
    pwm_in = '1;
    repeat (4) tick();
    #2;
    rst = 1'b0;
    #1;
    chk("rst_high", 32'(pwm_high), 32'd0);
    chk("rst_low", 32'(pwm_low), 32'd0);
    chk("rst_high_en", 32'(pwm_high_en), 32'd0);
    chk("rst_low_en", 32'(pwm_low_en), 32'd0);
    chk("rst_irq", 32'(fault_irq), 32'd0);
    reset_model();
    @(negedge clk);
    pwm_in = '0; pwm_en = '1; comp = '1;
    rst = 1'b1;
    repeat (3) tick();
    chk("low_after_rst", 32'(pwm_low), 32'hf);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
